vga_sync_module: RTL and testbench
==================================

VGA_SYNC_MODULE -- requirements
Module: vga_sync_module

Interface
REQ-001 SHALL have parameters H_SYNC=120, H_BP=64, H_ACT=800, H_FP=56 (pixel clocks per horizontal segment; total 1040).
REQ-002 SHALL have parameters V_SYNC=6, V_BP=23, V_ACT=600, V_FP=37 (lines per vertical segment; total 666).
REQ-003 SHALL have parameters H_POL=1 and V_POL=1 (asserted level of the HSYNC/VSYNC pulse).
REQ-004 SHALL have port CLK, input, 1, pixel clock (50 MHz for default timing).
REQ-005 SHALL have port RSTn, input, 1; one clock, RSTn asynchronous active-low reset.
REQ-006 SHALL have port HSYNC_Sig, output, 1, horizontal sync to the monitor.
REQ-007 SHALL have port VSYNC_Sig, output, 1, vertical sync to the monitor.
REQ-008 SHALL have port Ready_Sig, output, 1, high only inside the active picture area.
REQ-009 SHALL have port Column_Addr_Sig, output, 11, active-area pixel column 0..H_ACT-1.
REQ-010 SHALL have port Row_Addr_Sig, output, 11, active-area line 0..V_ACT-1.

Function
REQ-011 SHALL hold an 11-bit horizontal counter h counting 0..H_TOTAL-1 (H_TOTAL = sum of H params) and then wrapping to 0.
REQ-012 SHALL hold an 11-bit vertical counter v that increments only on the clock where h wraps, counting 0..V_TOTAL-1 and then wrapping to 0.
REQ-013 SHALL handle h and v wrapping on the same clock (h=1039, v=665) by returning both to 0 on that clock.
REQ-014 SHALL decode segment order per line as sync, back porch, active, front porch; for frames as sync, back porch, active, front porch.
REQ-015 SHALL drive HSYNC_Sig = H_POL when h < H_SYNC, else !H_POL.
REQ-016 SHALL drive VSYNC_Sig = V_POL when v < V_SYNC, else !V_POL.
REQ-017 SHALL assert Ready_Sig iff H_SYNC+H_BP <= h < H_SYNC+H_BP+H_ACT and V_SYNC+V_BP <= v < V_SYNC+V_BP+V_ACT (default h 184..983, v 29..628).
REQ-018 SHALL drive Column_Addr_Sig = h-(H_SYNC+H_BP) and Row_Addr_Sig = v-(V_SYNC+V_BP) while Ready_Sig is high, and 0 otherwise.
REQ-019 SHALL register all outputs: each output reflects the decode of the counter values present before the capturing edge, so every output lags the counters by exactly one clock.
REQ-020 SHALL keep all five outputs mutually cycle-aligned; the downstream pixel stage relies on this alignment.
REQ-021 SHALL never present an address outside 0..H_ACT-1 / 0..V_ACT-1.

Reset
REQ-022 SHALL, while RSTn is low, force h=0, v=0, HSYNC_Sig=!H_POL, VSYNC_Sig=!V_POL, Ready_Sig=0, Column_Addr_Sig=0, Row_Addr_Sig=0, independent of CLK.
REQ-023 SHALL abandon any partial line/frame on reset mid-frame and restart from h=0, v=0 at the first edge after release.

Structure
REQ-024 SHALL have the default timing constants and the derived totals and active-window bounds defined in shared package vga_timing_pkg, for reuse by vga_control_module and later VGA stages.
REQ-025 SHALL place the wrap-around counter with terminal-count output in one sub-module, vga_axis_counter, instantiated twice (h, and v enabled by h terminal count).

Verification
REQ-026 SHALL check reset: RSTn low mid-frame -> all outputs at reset values immediately; on release, first edge outputs show HSYNC_Sig=1, VSYNC_Sig=1, Ready_Sig=0.
REQ-027 SHALL check line timing: over one line, HSYNC_Sig is high for exactly 120 clocks, and rising edges of HSYNC_Sig are 1040 clocks apart.
REQ-028 SHALL check the first active pixel: Ready_Sig first rises 30345 edges after reset release (29*1040+184+1) with Column_Addr_Sig=0 and Row_Addr_Sig=0.
REQ-029 SHALL check the active window: each active line holds Ready_Sig high for exactly 800 clocks with Column_Addr_Sig stepping 0..799; a frame contains 600 active lines with Row 0..599; the address is 0 when Ready_Sig is low.
REQ-030 SHALL check frame wrap: VSYNC_Sig rising edges are 692640 clocks apart (1040*666), VSYNC_Sig is high for 6240 clocks, and h=1039, v=665 returns to 0,0 with no extra line.
REQ-031 SHALL check parameter override: a small mode (H 2/2/4/2, V 1/1/3/1, H_POL=0) produces an active-low 2-clock HSYNC, a 10-clock line, 4-pixel active runs, and a 6-line frame.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (800x600 @ 72 Hz, 50 MHz pixel clock) and
// segment-decode helpers used by every VGA pipeline stage.
package vga_timing_pkg;

    localparam int CNT_W = 11;

    localparam int DEF_H_SYNC = 120;
    localparam int DEF_H_BP   = 64;
    localparam int DEF_H_ACT  = 800;
    localparam int DEF_H_FP   = 56;

    localparam int DEF_V_SYNC = 6;
    localparam int DEF_V_BP   = 23;
    localparam int DEF_V_ACT  = 600;
    localparam int DEF_V_FP   = 37;

    localparam int DEF_H_TOTAL = DEF_H_SYNC + DEF_H_BP + DEF_H_ACT + DEF_H_FP;
    localparam int DEF_V_TOTAL = DEF_V_SYNC + DEF_V_BP + DEF_V_ACT + DEF_V_FP;

    // Active window bounds: start inclusive, end exclusive.
    localparam int DEF_H_ACT_START = DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_H_ACT_END   = DEF_H_ACT_START + DEF_H_ACT;
    localparam int DEF_V_ACT_START = DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_V_ACT_END   = DEF_V_ACT_START + DEF_V_ACT;

    typedef enum logic [1:0] {
        SEG_SYNC  = 2'd0,
        SEG_BP    = 2'd1,
        SEG_ACT   = 2'd2,
        SEG_FP    = 2'd3
    } vga_seg_e;

    typedef struct packed {
        logic             hsync;
        logic             vsync;
        logic             ready;
        logic [CNT_W-1:0] col;
        logic [CNT_W-1:0] row;
    } vga_sync_t;

    // Segments along one axis are ordered sync, back porch, active, front porch.
    function automatic vga_seg_e seg_decode(
        input logic [CNT_W-1:0] pos,
        input int               sync_len,
        input int               bp_len,
        input int               act_len
    );
        int p;
        p = int'(pos);
        if (p < sync_len)
            return SEG_SYNC;
        else if (p < sync_len + bp_len)
            return SEG_BP;
        else if (p < sync_len + bp_len + act_len)
            return SEG_ACT;
        else
            return SEG_FP;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap-around position counter for one VGA axis; tc_o marks the enabled
// clock on which the count returns to zero.
module vga_axis_counter #(
    parameter int W     = 11,
    parameter int TOTAL = 1040
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_last;

    assign at_last = (cnt_q == LAST);
    assign tc_o    = en_i && at_last;
    assign cnt_o   = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = at_last ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_sync_module.sv
// VGA sync generator: free-running h/v counters decoded into registered,
// mutually aligned HSYNC/VSYNC/Ready and active-area pixel addresses.
module vga_sync_module
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int H_ACT  = DEF_H_ACT,
    parameter int H_FP   = DEF_H_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP,
    parameter int V_ACT  = DEF_V_ACT,
    parameter int V_FP   = DEF_V_FP,
    parameter bit H_POL  = 1'b1,
    parameter bit V_POL  = 1'b1
) (
    input  logic             CLK,
    input  logic             RSTn,
    output logic             HSYNC_Sig,
    output logic             VSYNC_Sig,
    output logic             Ready_Sig,
    output logic [CNT_W-1:0] Column_Addr_Sig,
    output logic [CNT_W-1:0] Row_Addr_Sig
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

    localparam logic [CNT_W-1:0] H_ACT_START = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] V_ACT_START = CNT_W'(V_SYNC + V_BP);

    localparam vga_sync_t OUT_RST = '{
        hsync: !H_POL,
        vsync: !V_POL,
        ready: 1'b0,
        col:   '0,
        row:   '0
    };

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_tc;
    logic             v_tc_unused;

    vga_axis_counter #(
        .W     (CNT_W),
        .TOTAL (H_TOTAL)
    ) u_h_cnt (
        .clk   (CLK),
        .rst_n (RSTn),
        .en_i  (1'b1),
        .cnt_o (h_cnt),
        .tc_o  (h_tc)
    );

    // Line counter advances only on the clock where the pixel counter wraps.
    vga_axis_counter #(
        .W     (CNT_W),
        .TOTAL (V_TOTAL)
    ) u_v_cnt (
        .clk   (CLK),
        .rst_n (RSTn),
        .en_i  (h_tc),
        .cnt_o (v_cnt),
        .tc_o  (v_tc_unused)
    );

    vga_seg_e  h_seg;
    vga_seg_e  v_seg;
    vga_sync_t out_d;
    vga_sync_t out_q;

    always_comb begin
        h_seg       = seg_decode(h_cnt, H_SYNC, H_BP, H_ACT);
        v_seg       = seg_decode(v_cnt, V_SYNC, V_BP, V_ACT);

        out_d       = OUT_RST;
        out_d.hsync = (h_seg == SEG_SYNC) ? H_POL : !H_POL;
        out_d.vsync = (v_seg == SEG_SYNC) ? V_POL : !V_POL;
        out_d.ready = (h_seg == SEG_ACT) && (v_seg == SEG_ACT);
        // Addresses are forced to zero outside the picture so they never leave range.
        if (out_d.ready) begin
            out_d.col = h_cnt - H_ACT_START;
            out_d.row = v_cnt - V_ACT_START;
        end
    end

    // All five outputs share one register stage so they stay cycle-aligned.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            out_q <= OUT_RST;
        end else begin
            out_q <= out_d;
        end
    end

    assign HSYNC_Sig       = out_q.hsync;
    assign VSYNC_Sig       = out_q.vsync;
    assign Ready_Sig       = out_q.ready;
    assign Column_Addr_Sig = out_q.col;
    assign Row_Addr_Sig    = out_q.row;

endmodule

// File: tb/tb_vga_sync_module.sv
// Scoreboard bench: stimulus queues expected sync/active events for a default
// instance and a small-timing instance; one monitor pops and compares them.
module tb_vga_sync_module;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn_a, rstn_b;
    logic rst_probe, end_probe;

    logic        hs_a, vs_a, rdy_a;
    logic [10:0] col_a, row_a;
    logic        hs_b, vs_b, rdy_b;
    logic [10:0] col_b, row_b;

    vga_sync_module dut_a (
        .CLK             (clk),
        .RSTn            (rstn_a),
        .HSYNC_Sig       (hs_a),
        .VSYNC_Sig       (vs_a),
        .Ready_Sig       (rdy_a),
        .Column_Addr_Sig (col_a),
        .Row_Addr_Sig    (row_a)
    );

    vga_sync_module #(
        .H_SYNC (2), .H_BP (2), .H_ACT (4), .H_FP (2),
        .V_SYNC (1), .V_BP (1), .V_ACT (3), .V_FP (1),
        .H_POL  (1'b0), .V_POL (1'b1)
    ) dut_b (
        .CLK             (clk),
        .RSTn            (rstn_b),
        .HSYNC_Sig       (hs_b),
        .VSYNC_Sig       (vs_b),
        .Ready_Sig       (rdy_b),
        .Column_Addr_Sig (col_b),
        .Row_Addr_Sig    (row_b)
    );

    logic        rstn_s [2];
    logic        hs_s   [2];
    logic        vs_s   [2];
    logic        rdy_s  [2];
    logic [10:0] col_s  [2];
    logic [10:0] row_s  [2];
    assign rstn_s[0] = rstn_a; assign rstn_s[1] = rstn_b;
    assign hs_s[0]   = hs_a;   assign hs_s[1]   = hs_b;
    assign vs_s[0]   = vs_a;   assign vs_s[1]   = vs_b;
    assign rdy_s[0]  = rdy_a;  assign rdy_s[1]  = rdy_b;
    assign col_s[0]  = col_a;  assign col_s[1]  = col_b;
    assign row_s[0]  = row_a;  assign row_s[1]  = row_b;

    // Expected events, per instance.
    logic [31:0] exp_hs_on  [2][$];   // edge index where HSYNC becomes asserted
    logic [31:0] exp_hs_w   [2][$];   // asserted HSYNC width in clocks
    logic [31:0] exp_vs_on  [2][$];
    logic [31:0] exp_vs_w   [2][$];
    logic [53:0] exp_rdy_on [2][$];   // {edge, col, row} at Ready rise
    logic [43:0] exp_run    [2][$];   // {width, last col, step error}
    logic [2:0]  exp_first  [$];      // {hs, vs, rdy} after first edge, instance a
    logic [24:0] exp_rst    [$];      // {hs, vs, rdy, col, row} during reset, instance a

    int checks = 0;
    int errors = 0;

    int          e_cnt     [2];
    logic        hs_prev   [2];
    logic        vs_prev   [2];
    logic        rdy_prev  [2];
    int          hs_t      [2];
    int          vs_t      [2];
    int          run_len   [2];
    logic [10:0] last_col  [2];
    logic [10:0] run_row   [2];
    logic        step_err  [2];
    int          zero_viol [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk or posedge rst_probe or posedge end_probe) begin
        logic hs_act, vs_act, hpol;
        int   left;
        if (rst_probe) begin
            if (exp_rst.size() > 0)
                chk("reset_async_a", {hs_a, vs_a, rdy_a, col_a, row_a}, exp_rst.pop_front());
        end else if (end_probe) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("addr_zero_when_idle_%0d", i), zero_viol[i], 0);
                left = exp_hs_on[i].size() + exp_hs_w[i].size() + exp_vs_on[i].size()
                     + exp_vs_w[i].size() + exp_rdy_on[i].size() + exp_run[i].size();
                chk($sformatf("events_missing_%0d", i), left, 0);
            end
            chk("events_missing_first_rst", exp_first.size() + exp_rst.size(), 0);
        end else begin
            for (int i = 0; i < 2; i++) begin
                hpol = (i == 0) ? 1'b1 : 1'b0;
                if (!rstn_s[i]) begin
                    e_cnt[i]    = 0;
                    hs_prev[i]  = 1'b0;
                    vs_prev[i]  = 1'b0;
                    rdy_prev[i] = 1'b0;
                end else begin
                    e_cnt[i]++;
                    hs_act = (hs_s[i] == hpol);
                    vs_act = (vs_s[i] == 1'b1);
                    if (i == 0 && e_cnt[i] == 1 && exp_first.size() > 0)
                        chk("first_edge_a", {hs_s[i], vs_s[i], rdy_s[i]}, exp_first.pop_front());
                    if (hs_act && !hs_prev[i]) begin
                        hs_t[i] = e_cnt[i];
                        if (exp_hs_on[i].size() > 0)
                            chk($sformatf("hs_on_%0d", i), e_cnt[i], exp_hs_on[i].pop_front());
                    end
                    if (!hs_act && hs_prev[i] && exp_hs_w[i].size() > 0)
                        chk($sformatf("hs_width_%0d", i), e_cnt[i] - hs_t[i], exp_hs_w[i].pop_front());
                    if (vs_act && !vs_prev[i]) begin
                        vs_t[i] = e_cnt[i];
                        if (exp_vs_on[i].size() > 0)
                            chk($sformatf("vs_on_%0d", i), e_cnt[i], exp_vs_on[i].pop_front());
                    end
                    if (!vs_act && vs_prev[i] && exp_vs_w[i].size() > 0)
                        chk($sformatf("vs_width_%0d", i), e_cnt[i] - vs_t[i], exp_vs_w[i].pop_front());
                    if (rdy_s[i]) begin
                        if (!rdy_prev[i]) begin
                            run_len[i]  = 1;
                            run_row[i]  = row_s[i];
                            last_col[i] = col_s[i];
                            step_err[i] = 1'b0;
                            if (exp_rdy_on[i].size() > 0)
                                chk($sformatf("ready_rise_%0d", i),
                                    {e_cnt[i][31:0], col_s[i], row_s[i]}, exp_rdy_on[i].pop_front());
                        end else begin
                            if (col_s[i] != last_col[i] + 11'd1 || row_s[i] != run_row[i])
                                step_err[i] = 1'b1;
                            last_col[i] = col_s[i];
                            run_len[i]++;
                        end
                    end else begin
                        if (col_s[i] != 11'd0 || row_s[i] != 11'd0)
                            zero_viol[i]++;
                        if (rdy_prev[i] && exp_run[i].size() > 0)
                            chk($sformatf("active_run_%0d", i),
                                {run_len[i][31:0], last_col[i], step_err[i]}, exp_run[i].pop_front());
                    end
                    hs_prev[i]  = hs_act;
                    vs_prev[i]  = vs_act;
                    rdy_prev[i] = rdy_s[i];
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) zero_viol[i] = 0;
        rstn_a = 1'b0; rstn_b = 1'b0; rst_probe = 1'b0; end_probe = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;

        // Phase 1, default instance: run into the first active line.
        exp_hs_on[0].push_back(1); exp_hs_on[0].push_back(1041);
        exp_hs_w[0].push_back(120);
        exp_vs_on[0].push_back(1);
        exp_rdy_on[0].push_back({32'd30345, 11'd0, 11'd0});

        // Small instance: active-low 2-clock HSYNC, 10-clock line, 6-line frame.
        for (int n = 0; n < 12; n++) begin
            exp_hs_on[1].push_back(32'(1 + 10 * n));
            exp_hs_w[1].push_back(2);
        end
        for (int f = 0; f < 3; f++) begin
            exp_vs_on[1].push_back(32'(1 + 60 * f));
            exp_vs_w[1].push_back(10);
        end
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < 3; r++) begin
                exp_rdy_on[1].push_back({32'(25 + 10 * r + 60 * f), 11'd0, 11'(r)});
                exp_run[1].push_back({32'd4, 11'd3, 1'b0});
            end
        end
        rstn_a = 1'b1; rstn_b = 1'b1;

        // Reset mid active line (col 9): outputs must clear without a clock edge.
        repeat (30354) @(posedge clk);
        #2 rstn_a = 1'b0;
        exp_rst.push_back({1'b0, 1'b0, 1'b0, 11'd0, 11'd0});
        #1 rst_probe = 1'b1;
        #1 rst_probe = 1'b0;
        repeat (3) @(negedge clk); #1;

        // Phase 2, default instance: restart from h=0, v=0.
        exp_first.push_back({1'b1, 1'b1, 1'b0});
        exp_hs_on[0].push_back(1); exp_hs_on[0].push_back(1041); exp_hs_on[0].push_back(2081);
        exp_hs_w[0].push_back(120); exp_hs_w[0].push_back(120);
        exp_vs_on[0].push_back(1);
        exp_vs_w[0].push_back(6240);
        exp_rdy_on[0].push_back({32'd30345, 11'd0, 11'd0});
        exp_rdy_on[0].push_back({32'd31385, 11'd0, 11'd1});
        exp_run[0].push_back({32'd800, 11'd799, 1'b0});
        exp_run[0].push_back({32'd800, 11'd799, 1'b0});
        rstn_a = 1'b1;

        repeat (32300) @(posedge clk);
        #2 end_probe = 1'b1;
        #1 end_probe = 1'b0;
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
